// File: rtl/timer_service_master.sv
// Bus master that services timeout interrupts from a timer slave: enables the
// irq, acknowledges each timeout, and guards every wait with a watchdog.
module timer_service_master #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 16,
    parameter int WDOG_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       tick_target,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              irq,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       tick_count
);
    localparam int                WD_W        = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(WDOG_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = '0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE, EN_IRQ, WAIT_IRQ, RD_STAT, RD_WAIT, CLR_STAT, DIS_IRQ
    } state_t;

    state_t          state;
    logic [15:0]     target;
    logic [WD_W-1:0] wdog;
    logic            settle;
    logic [15:0]     count_next;
    logic            unused_readdata;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign count_next      = sat_inc(tick_count);
    assign unused_readdata = ^readdata[DATA_W-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            address    <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            tick_count <= '0;
            target     <= '0;
            wdog       <= '0;
            settle     <= 1'b0;
        end else begin
            // Bus outputs are registered: the access for a state is set up
            // on the transition into it, and the bus idles by default.
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        tick_count <= '0;
                        if (tick_target == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            target     <= tick_target;
                            busy       <= 1'b1;
                            state      <= EN_IRQ;
                            chipselect <= 1'b1;
                            write_n    <= 1'b0;
                            address    <= ADDR_CTRL;
                            writedata  <= DATA_W'(1);
                        end
                    end
                end
                EN_IRQ: begin
                    state  <= WAIT_IRQ;
                    wdog   <= '0;
                    settle <= 1'b0;
                end
                WAIT_IRQ: begin
                    // The cycle right after a clear write is skipped so the
                    // slave's stale irq level is never taken as a new timeout.
                    settle <= 1'b0;
                    if (irq && !settle) begin
                        state      <= RD_STAT;
                        chipselect <= 1'b1;
                        address    <= ADDR_STATUS;
                    end else if (wdog == WD_LAST) begin
                        error      <= 1'b1;
                        state      <= DIS_IRQ;
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= ADDR_CTRL;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RD_STAT: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    if (readdata[0]) begin
                        state   <= CLR_STAT;
                        address <= ADDR_STATUS;
                    end else begin
                        error   <= 1'b1;
                        state   <= DIS_IRQ;
                        address <= ADDR_CTRL;
                    end
                end
                CLR_STAT: begin
                    tick_count <= count_next;
                    if (count_next == target) begin
                        state      <= DIS_IRQ;
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= ADDR_CTRL;
                    end else begin
                        state  <= WAIT_IRQ;
                        wdog   <= '0;
                        settle <= 1'b1;
                    end
                end
                DIS_IRQ: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= !error;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_service_master.sv
// Randomized scoreboard bench for timer_service_master with a behavioural
// timer slave and a transaction-level reference of each run.
module tb_timer_service_master;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int WDOG   = 100;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       tick_target = '0;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       tick_count;

    always #5 clk = ~clk;

    timer_service_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tick_target(tick_target),
        .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq),
        .busy(busy), .done(done), .error(error), .tick_count(tick_count)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] data;
    } bus_op_t;

    typedef struct packed {
        logic        done;
        logic        error;
        logic [15:0] count;
    } end_t;

    bus_op_t exp_bus[$];
    end_t    exp_end[$];
    int      vectors = 0;
    int      miscompares = 0;
    int      ends_seen = 0;
    int      cyc = 0;
    int      rd_cyc = 0;
    int      en_cyc = 0;
    int      dis_cyc = 0;
    logic    busy_prev = 1'b0;

    // Timer slave: status (bit0 timeout, bit1 running) and control (bit0 ie).
    logic force_irq = 1'b0;
    logic bad_status = 1'b0;
    logic timer_en = 1'b1;
    logic timeout_r;
    logic ie_r;
    int   gap_cnt;
    int   gap_len;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_r <= 1'b0;
            ie_r      <= 1'b0;
            readdata  <= '0;
            gap_cnt   <= 0;
            gap_len   <= 5;
        end else begin
            if (chipselect && !write_n) begin
                gap_cnt <= 0;
                gap_len <= $urandom_range(1, 30);
                if (address == 0) timeout_r <= 1'b0;
                else if (address == 1) ie_r <= writedata[0];
            end else if (ie_r && !timeout_r && timer_en) begin
                if (gap_cnt >= gap_len) timeout_r <= 1'b1;
                else gap_cnt <= gap_cnt + 1;
            end
            if (chipselect && write_n)
                readdata <= bad_status ? 16'h0002 :
                            (address == 0) ? {14'd0, ie_r, timeout_r} : {15'd0, ie_r};
        end
    end

    assign irq = force_irq | (timeout_r & ie_r);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    function automatic bus_op_t wr_op(input int a, input int d);
        bus_op_t op;
        op.addr = ADDR_W'(a);
        op.wr   = 1'b1;
        op.data = DATA_W'(d);
        return op;
    endfunction

    function automatic bus_op_t rd_op(input int a);
        bus_op_t op;
        op.addr = ADDR_W'(a);
        op.wr   = 1'b0;
        op.data = '0;
        return op;
    endfunction

    // kind: 0 normal service, 1 irq never arrives, 2 irq with bad status
    task automatic expect_run(input logic [15:0] tgt, input int kind);
        end_t e;
        if (tgt == 16'd0) begin
            e = '{1'b1, 1'b0, 16'd0};
            exp_end.push_back(e);
            return;
        end
        exp_bus.push_back(wr_op(1, 1));
        if (kind == 0) begin
            for (int i = 0; i < int'(tgt); i++) begin
                exp_bus.push_back(rd_op(0));
                exp_bus.push_back(wr_op(0, 0));
            end
            e = '{1'b1, 1'b0, tgt};
        end else begin
            if (kind == 2) exp_bus.push_back(rd_op(0));
            e = '{1'b0, 1'b1, 16'd0};
        end
        exp_bus.push_back(wr_op(1, 0));
        exp_end.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
        end else begin
            cyc++;
            if (chipselect) begin
                if (exp_bus.size() == 0) begin
                    fail("unexpected_bus_access");
                end else begin
                    bus_op_t op;
                    op = exp_bus.pop_front();
                    check("bus_addr", 32'(address), 32'(op.addr));
                    check("bus_write", 32'(!write_n), 32'(op.wr));
                    if (op.wr) check("bus_wdata", 32'(writedata), 32'(op.data));
                    if (!op.wr) rd_cyc = cyc;
                    if (op.wr && op.addr == 0) check("read_to_clear_latency", 32'(cyc - rd_cyc), 32'd2);
                    if (op.wr && op.addr == 1 && op.data == 1) en_cyc = cyc;
                    if (op.wr && op.addr == 1 && op.data == 0) dis_cyc = cyc;
                end
            end else begin
                check("idle_write_n", 32'(write_n), 32'd1);
            end
            if (done && busy) fail("done_while_busy");
            if ((busy_prev && !busy) || (done && !busy_prev)) begin
                if (exp_end.size() == 0) begin
                    fail("unexpected_run_end");
                end else begin
                    end_t e;
                    e = exp_end.pop_front();
                    check("end_done", 32'(done), 32'(e.done));
                    check("end_error", 32'(error), 32'(e.error));
                    check("end_tick_count", 32'(tick_count), 32'(e.count));
                end
                ends_seen++;
            end
            busy_prev = busy;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_chipselect"}, 32'(chipselect), 32'd0);
        check({tag, "_write_n"}, 32'(write_n), 32'd1);
        check({tag, "_address"}, 32'(address), 32'd0);
        check({tag, "_writedata"}, 32'(writedata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_tick_count"}, 32'(tick_count), 32'd0);
    endtask

    task automatic run(input logic [15:0] tgt, input int kind, input bit inject);
        int base;
        int waited;
        force_irq  = (kind == 2);
        bad_status = (kind == 2);
        timer_en   = (kind != 1);
        expect_run(tgt, kind);
        base = ends_seen;
        @(posedge clk); #1;
        start = 1'b1;
        tick_target = tgt;
        @(posedge clk); #1;
        start = 1'b0;
        tick_target = 16'($urandom);
        @(negedge clk);
        if (tgt == 16'd0) begin
            check("zero_done_next_cycle", 32'(done), 32'd1);
            check("zero_busy", 32'(busy), 32'd0);
        end else begin
            check("start_busy", 32'(busy), 32'd1);
            check("start_error_cleared", 32'(error), 32'd0);
            check("start_tick_count", 32'(tick_count), 32'd0);
        end
        waited = 0;
        while (ends_seen == base && waited < 5000) begin
            @(posedge clk); #1;
            if (inject && busy && !start && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                tick_target = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            waited++;
        end
        start = 1'b0;
        if (ends_seen == base) fail("run_timeout");
        force_irq  = 1'b0;
        bad_status = 1'b0;
        timer_en   = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // irq while idle must not cause any bus access
        @(posedge clk); #1;
        force_irq = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("idle_irq_busy", 32'(busy), 32'd0);
        force_irq = 1'b0;

        run(16'd0, 0, 1'b0);
        run(16'd3, 0, 1'b1);
        run(16'd1, 1, 1'b0);
        check("wdog_en_to_dis_cycles", 32'(dis_cyc - en_cyc), 32'(WDOG + 1));
        run(16'd2, 2, 1'b0);
        run(16'd2, 0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 6)      run(16'($urandom_range(1, 5)), 0, 1'b1);
            else if (r == 7) run(16'($urandom_range(1, 5)), 1, 1'b1);
            else if (r == 8) run(16'($urandom_range(1, 5)), 2, 1'b1);
            else             run(16'd0, 0, 1'b0);
        end

        // abort a run from RD_WAIT with reset
        @(posedge clk); #1;
        start = 1'b1;
        tick_target = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        exp_bus.push_back(wr_op(1, 1));
        exp_bus.push_back(rd_op(0));
        waited = 0;
        while (!(chipselect && write_n) && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 2000) fail("read_wait_timeout");
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        exp_bus.delete();
        exp_end.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        run(16'd2, 0, 1'b0);

        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("end_queue_drained", 32'(exp_end.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end
endmodule
